sprite_table: RTL and testbench

Avalon-MM slave holding the sprite attribute table that feeds `Sprite_Controller`. The CPU writes sprite descriptors into a staging table. The block copies staging to a shadow table at vertical-blank start when a commit is pending. During each horizontal blank it scans the shadow table and presents up to three sprites that intersect the next scanline on `sprite1..3`.

---
 rtl/sprite_table.sv | 120 ++++++++++++
 tb/tb_sprite_table.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_table.sv
// sprite_table: Avalon-MM sprite attribute table, vblank-committed shadow copy
// and a per-hblank scan that publishes up to three sprites for the next line.
module sprite_table #(
  parameter int NUM_SPRITES = 16,
  parameter int SPRITE_H = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [9:0]  VGA_HCOUNT,
  input  logic [9:0]  VGA_VCOUNT,
  output logic [23:0] sprite1,
  output logic [23:0] sprite2,
  output logic [23:0] sprite3,
  output logic        irq
);
  typedef enum logic [1:0] {IDLE, SCAN, PUBLISH} state_t;
  state_t state_q;
  logic [23:0] stage_q [NUM_SPRITES];
  logic [23:0] shadow_q [NUM_SPRITES];
  logic [23:0] cand_q [3];
  logic [23:0] sprite_q [3];
  logic [9:0] hprev_q, vprev_q, target_q;
  logic [4:0] idx_q;
  logic [1:0] cnt_q;
  logic pending_q, overflow_q, irq_q;
  logic [7:0] frame_q;
  logic [31:0] readdata_q, readdata_d;
  logic [23:0] entry_d, stage_rd;
  logic [10:0] y_ext, t_ext;
  logic hblank_start, vblank_start, hit, wr, unused_ok;
  assign wr = chipselect && write;
  assign hblank_start = VGA_HCOUNT == 10'd640 && hprev_q != 10'd640;
  assign vblank_start = VGA_VCOUNT == 10'd480 && VGA_HCOUNT == 10'd0 &&
                        !(vprev_q == 10'd480 && hprev_q == 10'd0);
  assign unused_ok = ^writedata[31:24];
  assign readdata = readdata_q;
  assign sprite1 = sprite_q[0];
  assign sprite2 = sprite_q[1];
  assign sprite3 = sprite_q[2];
  assign irq = irq_q;
  // 11-bit compare keeps y near 1023 from wrapping into low lines
  always_comb begin
    entry_d = '0;
    stage_rd = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      entry_d = idx_q == 5'(i) ? shadow_q[i] : entry_d;
      stage_rd = address == 5'(i) ? stage_q[i] : stage_rd;
    end
    y_ext = {1'b0, entry_d[9:0]};
    t_ext = {1'b0, target_q};
    hit = entry_d[23:19] != 5'd0 && t_ext >= y_ext && t_ext <= y_ext + 11'(SPRITE_H - 1);
    readdata_d = address == 5'd31 ? {16'd0, frame_q, 6'd0, overflow_q, pending_q} : {8'd0, stage_rd};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        stage_q[i] <= '0;
        shadow_q[i] <= '0;
      end
      for (int i = 0; i < 3; i++) begin
        cand_q[i] <= '0;
        sprite_q[i] <= '0;
      end
      state_q <= IDLE;
      hprev_q <= '0;
      vprev_q <= '0;
      target_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      pending_q <= 1'b0;
      overflow_q <= 1'b0;
      irq_q <= 1'b0;
      frame_q <= '0;
      readdata_q <= '0;
    end else begin
      hprev_q <= VGA_HCOUNT;
      vprev_q <= VGA_VCOUNT;
      irq_q <= vblank_start;
      if (chipselect && read) readdata_q <= readdata_d;
      if (vblank_start) begin
        frame_q <= frame_q + 8'd1;
        if (pending_q) begin
          for (int i = 0; i < NUM_SPRITES; i++) shadow_q[i] <= stage_q[i];
          pending_q <= 1'b0;
          overflow_q <= 1'b0;
        end
      end
      for (int i = 0; i < NUM_SPRITES; i++)
        if (wr && address == 5'(i)) stage_q[i] <= writedata[23:0];
      if (wr && address == 5'd30 && writedata[0]) pending_q <= 1'b1;
      case (state_q)
        IDLE: if (hblank_start) begin
          state_q <= SCAN;
          target_q <= VGA_VCOUNT == 10'd524 ? 10'd0 : VGA_VCOUNT + 10'd1;
          idx_q <= '0;
          cnt_q <= '0;
          for (int i = 0; i < 3; i++) cand_q[i] <= '0;
        end
        SCAN: begin
          for (int i = 0; i < 3; i++)
            if (hit && cnt_q == 2'(i)) cand_q[i] <= entry_d;
          if (hit && cnt_q != 2'd3) cnt_q <= cnt_q + 2'd1;
          if (hit && cnt_q == 2'd3) overflow_q <= 1'b1;
          idx_q <= idx_q + 5'd1;
          if (idx_q == 5'(NUM_SPRITES - 1)) state_q <= PUBLISH;
        end
        default: begin
          for (int i = 0; i < 3; i++) sprite_q[i] <= cand_q[i];
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sprite_table.sv
// tb_sprite_table: randomized and directed checks of sprite_table against a table-level model.
module tb_sprite_table;
  localparam int NS = 16;
  localparam int SH = 32;
  logic clk = 1'b0, reset = 1'b1, chipselect = 1'b0, read = 1'b0, write = 1'b0;
  logic [4:0] address = '0;
  logic [31:0] writedata = '0, readdata;
  logic [9:0] hcnt = 10'd700, vcnt = 10'd0;
  logic [23:0] sprite1, sprite2, sprite3;
  logic irq;
  int errs = 0, checks = 0;
  logic [23:0] stage_m [NS];
  logic [23:0] shadow_m [NS];
  logic pending_m, ovf_m;
  logic [7:0] frame_m;
  logic [31:0] d;

  sprite_table #(.NUM_SPRITES(NS), .SPRITE_H(SH)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .read(read), .write(write),
    .address(address), .writedata(writedata), .readdata(readdata),
    .VGA_HCOUNT(hcnt), .VGA_VCOUNT(vcnt),
    .sprite1(sprite1), .sprite2(sprite2), .sprite3(sprite3), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [23:0] ent(input int id, input int x, input int y);
    return {5'(id), 9'(x), 10'(y)};
  endfunction

  function automatic logic [31:0] status_m();
    return {16'd0, frame_m, 6'd0, ovf_m, pending_m};
  endfunction

  task automatic mreset();
    for (int i = 0; i < NS; i++) begin
      stage_m[i] = '0;
      shadow_m[i] = '0;
    end
    pending_m = 1'b0;
    ovf_m = 1'b0;
    frame_m = '0;
  endtask

  task automatic mwrite(input int a, input logic [31:0] v);
    if (a < NS) stage_m[a] = v[23:0];
    if (a == 30 && v[0]) pending_m = 1'b1;
  endtask

  task automatic wr(input int a, input logic [31:0] v);
    chipselect = 1'b1; write = 1'b1; address = 5'(a); writedata = v;
    tick();
    chipselect = 1'b0; write = 1'b0;
    mwrite(a, v);
  endtask

  task automatic rd(input int a, output logic [31:0] v);
    chipselect = 1'b1; read = 1'b1; address = 5'(a);
    tick();
    chipselect = 1'b0; read = 1'b0;
    v = readdata;
  endtask

  task automatic chk_rd(input int a);
    logic [31:0] v;
    rd(a, v);
    chk($sformatf("rd_%0d", a), v, a == 31 ? status_m() : (a < NS ? {8'd0, stage_m[a]} : 32'd0));
  endtask

  // op: 0 none, 1 write a/v on the vblank cycle, 2 status read on the vblank cycle
  task automatic vblank(input int op, input int a, input logic [31:0] v);
    logic [31:0] pre;
    pre = status_m();
    vcnt = 10'd480; hcnt = 10'd799;
    tick();
    chk("irq_pre", {31'd0, irq}, 32'd0);
    hcnt = 10'd0;
    if (op == 1) begin chipselect = 1'b1; write = 1'b1; address = 5'(a); writedata = v; end
    if (op == 2) begin chipselect = 1'b1; read = 1'b1; address = 5'd31; end
    tick();
    chipselect = 1'b0; write = 1'b0; read = 1'b0;
    chk("irq_pulse", {31'd0, irq}, 32'd1);
    if (op == 2) chk("vb_status", readdata, pre);
    frame_m++;
    if (pending_m) begin
      for (int i = 0; i < NS; i++) shadow_m[i] = stage_m[i];
      pending_m = 1'b0;
      ovf_m = 1'b0;
    end
    if (op == 1) mwrite(a, v);
    hcnt = 10'd1;
    tick();
    chk("irq_post", {31'd0, irq}, 32'd0);
    hcnt = 10'd700;
  endtask

  task automatic line(input int v);
    int t, n;
    logic [23:0] want [3];
    t = (v == 524) ? 0 : v + 1;
    n = 0;
    for (int k = 0; k < 3; k++) want[k] = '0;
    for (int i = 0; i < NS; i++) begin
      int y;
      y = int'(shadow_m[i][9:0]);
      if (shadow_m[i][23:19] != 5'd0 && t >= y && t < y + SH) begin
        if (n < 3) want[n] = shadow_m[i];
        else ovf_m = 1'b1;
        n++;
      end
    end
    vcnt = 10'(v); hcnt = 10'd639;
    tick();
    hcnt = 10'd640;
    tick();
    hcnt = 10'd641;
    repeat (NS + 2) tick();
    hcnt = 10'd700;
    tick();
    chk($sformatf("s1_l%0d", v), {8'd0, sprite1}, {8'd0, want[0]});
    chk($sformatf("s2_l%0d", v), {8'd0, sprite2}, {8'd0, want[1]});
    chk($sformatf("s3_l%0d", v), {8'd0, sprite3}, {8'd0, want[2]});
  endtask

  initial begin
    mreset();
    repeat (3) tick();
    chk("rst_s1", {8'd0, sprite1}, 32'd0);
    chk("rst_rd", readdata, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;
    tick();
    // readback
    wr(3, 32'h000ABCDE);
    rd(3, d);
    chk("rd_entry3", d, 32'h000ABCDE);
    chk_rd(31);
    // commit timing
    wr(0, {8'd0, ent(1, 100, 50)});
    line(49);
    wr(30, 32'd1);
    chk_rd(31);
    line(49);
    vblank(0, 0, 0);
    chk_rd(31);
    line(48);
    line(49);
    line(80);
    line(81);
    // priority and overflow
    wr(2, {8'd0, ent(2, 10, 100)});
    wr(5, {8'd0, ent(3, 20, 100)});
    wr(7, {8'd0, ent(4, 30, 100)});
    wr(0, {8'd0, ent(1, 40, 100)});
    wr(30, 32'd1);
    vblank(0, 0, 0);
    line(99);
    chk_rd(31);
    wr(30, 32'd1);
    vblank(0, 0, 0);
    chk_rd(31);
    line(99);
    chk_rd(0);
    // async reset in the middle of a scan
    vcnt = 10'd99; hcnt = 10'd639;
    tick();
    hcnt = 10'd640;
    tick();
    hcnt = 10'd641;
    repeat (3) tick();
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_s1", {8'd0, sprite1}, 32'd0);
    chk("mid_rst_s2", {8'd0, sprite2}, 32'd0);
    chk("mid_rst_s3", {8'd0, sprite3}, 32'd0);
    chk("mid_rst_rd", readdata, 32'd0);
    tick();
    reset = 1'b0;
    hcnt = 10'd700;
    mreset();
    tick();
    chk_rd(31);
    line(99);
    // wrap and edges
    wr(1, {8'd0, ent(2, 5, 1010)});
    wr(4, {8'd0, ent(3, 6, 0)});
    wr(6, {8'd0, ent(4, 7, 493)});
    wr(30, 32'd1);
    vblank(0, 0, 0);
    foreach (stage_m[i]) if (i == 0) begin end
    line(524);
    line(523);
    line(492);
    line(491);
    line(0);
    line(30);
    line(31);
    line(460);
    // simultaneous events on the vblank cycle
    wr(0, {8'd0, ent(5, 50, 300)});
    wr(30, 32'd1);
    vblank(0, 0, 0);
    wr(30, 32'd1);
    vblank(1, 30, 32'd1);
    chk_rd(31);
    vblank(1, 0, {8'd0, ent(6, 60, 300)});
    line(299);
    chk_rd(31);
    wr(30, 32'd1);
    vblank(2, 0, 0);
    line(299);
    // randomized tables and lines
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NS; i++) begin
        int id, y;
        id = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 31));
        y = ($urandom_range(0, 7) == 0) ? int'($urandom_range(990, 1023)) : int'($urandom_range(0, 160));
        wr(i, {8'($urandom), ent(id, int'($urandom_range(0, 511)), y)});
      end
      chk_rd(int'($urandom_range(0, 31)));
      chk_rd(int'($urandom_range(0, NS - 1)));
      wr(30, 32'd1);
      vblank(0, 0, 0);
      for (int k = 0; k < 10; k++) line(int'($urandom_range(0, 200)));
      line(524);
      chk_rd(31);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
